// File: rtl/digi_disp_capture_if.sv
// Bus bundle for the 7-segment display capture block.
//   master : the scanning side (drives Seg_in / Sl_in / Clr, observes results)
//   slave  : the capture block (samples the scan bus, reports frames and flags)
// Signals:
//   Seg_in    [7:0] segment bus, bit0..6 = a..g active-high, bit7 = dp
//   Sl_in     [3:0] active-low one-hot digit select, bit0 = digit a
//   Clr             clears sticky error flags
//   Dig_a..d  [3:0] decoded digits of the last complete frame
//   Blank     [3:0] per-digit blank flags, bit order as Sl_in
//   Frame_vld       one-cycle pulse when Dig_* / Blank take a new frame
//   Seg_err / Sel_err / Ord_err  sticky error flags
//   Stall           scan timeout active
interface digi_disp_capture_if;
  logic [7:0] Seg_in;
  logic [3:0] Sl_in;
  logic       Clr;
  logic [3:0] Dig_a;
  logic [3:0] Dig_b;
  logic [3:0] Dig_c;
  logic [3:0] Dig_d;
  logic [3:0] Blank;
  logic       Frame_vld;
  logic       Seg_err;
  logic       Sel_err;
  logic       Ord_err;
  logic       Stall;

  modport master (
    output Seg_in, Sl_in, Clr,
    input  Dig_a, Dig_b, Dig_c, Dig_d, Blank, Frame_vld,
    input  Seg_err, Sel_err, Ord_err, Stall
  );

  modport slave (
    input  Seg_in, Sl_in, Clr,
    output Dig_a, Dig_b, Dig_c, Dig_d, Blank, Frame_vld,
    output Seg_err, Sel_err, Ord_err, Stall
  );
endinterface

// File: rtl/digi_disp_capture.sv
// Receive end of a 4-digit multiplexed 7-segment display. Synchronizes the
// scanned segment bus and digit selects, commits one decoded digit per stable
// select dwell, reassembles a->b->c->d frames and flags malformed scans.
// Ports:
//   Clk        clock, all logic on the rising edge
//   Reset      synchronous active-high reset
//   bus        digi_disp_capture_if.slave (scan inputs, Clr, frame outputs, flags)
// Parameters:
//   STABLE_CYC  cycles the synchronized (Sl,Seg) pair must hold before commit (>=1)
//   TIMEOUT_CYC cycles without a commit before Stall asserts (>=8)
module digi_disp_capture #(
  parameter int STABLE_CYC  = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               Clk,
  input logic               Reset,
  digi_disp_capture_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYC);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic {WAIT0, COLLECT} state_t;

  // Returns {bad, blank, value}.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:        return 6'h00;
      7'h06:        return 6'h01;
      7'h5B:        return 6'h02;
      7'h4F:        return 6'h03;
      7'h66:        return 6'h04;
      7'h6D:        return 6'h05;
      7'h7C, 7'h7D: return 6'h06;
      7'h07:        return 6'h07;
      7'h7F:        return 6'h08;
      7'h67, 7'h6F: return 6'h09;
      7'h00:        return {2'b01, 4'hF};
      default:      return {2'b10, 4'hF};
    endcase
  endfunction

  function automatic logic [SW-1:0] stab_inc(input logic [SW-1:0] c);
    return (c == STABLE_MAX) ? c : c + SW'(1);
  endfunction

  function automatic logic [TW-1:0] idle_inc(input logic [TW-1:0] c);
    return (c == TIMEOUT_MAX) ? c : c + TW'(1);
  endfunction

  logic [6:0] seg_p0, seg_p1, seg_p2;
  logic [3:0] sl_p0, sl_p1, sl_p2;
  logic       dp_unused;

  assign dp_unused = bus.Seg_in[7];

  // Stage p0/p1: two-flop synchronizers; p2 keeps the previous synchronized pair
  always_ff @(posedge Clk) begin
    seg_p0 <= bus.Seg_in[6:0];
    seg_p1 <= seg_p0;
    seg_p2 <= seg_p1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sl_p0 <= 4'hF;
      sl_p1 <= 4'hF;
      sl_p2 <= 4'hF;
    end else begin
      sl_p0 <= bus.Sl_in;
      sl_p1 <= sl_p0;
      sl_p2 <= sl_p1;
    end
  end

  // Stage p1: select classification, stability and commit
  logic       sel_one, sel_idle, sel_bad;
  logic [1:0] sel_idx;

  always_comb begin
    sel_one = 1'b0;
    sel_idx = 2'd0;
    case (sl_p1)
      4'b1110: begin sel_one = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_one = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_one = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_one = 1'b1; sel_idx = 2'd3; end
      default: ;
    endcase
  end

  assign sel_idle = (sl_p1 == 4'hF);
  assign sel_bad  = !sel_idle && !sel_one;

  logic          sl_chg, pair_chg, commit, dwell_done_q;
  logic [SW-1:0] stab_q, stab_now;
  logic [5:0]    dec;

  assign sl_chg   = (sl_p1 != sl_p2);
  assign pair_chg = sl_chg || (seg_p1 != seg_p2);
  assign stab_now = pair_chg ? SW'(1) : stab_inc(stab_q);
  // A dwell ends only when Sl changes, so a Seg change after the commit
  // restarts the counter but cannot produce a second commit.
  assign commit   = sel_one && (stab_now == STABLE_MAX) && !(dwell_done_q && !sl_chg);
  assign dec      = seg_decode(seg_p1);

  // Stage p2: frame state machine
  state_t        state_q, state_d;
  logic [1:0]    exp_q, exp_d;
  logic          sh_we, ord_set, frame_go_d, frame_go_q;
  logic [TW-1:0] idle_q, idle_d;

  assign idle_d = commit ? '0 : idle_inc(idle_q);

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    sh_we      = 1'b0;
    ord_set    = 1'b0;
    frame_go_d = 1'b0;
    if (commit) begin
      case (state_q)
        WAIT0: begin
          if (sel_idx == 2'd0) begin
            sh_we   = 1'b1;
            exp_d   = 2'd1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (sel_idx == exp_q) begin
            sh_we      = 1'b1;
            exp_d      = exp_q + 2'd1;
            frame_go_d = (exp_q == 2'd3);
          end else begin
            ord_set = 1'b1;
            if (sel_idx == 2'd0) begin
              sh_we = 1'b1;
              exp_d = 2'd1;
            end else begin
              state_d = WAIT0;
            end
          end
        end
        default: state_d = WAIT0;
      endcase
    end else if (idle_d == TIMEOUT_MAX) begin
      state_d = WAIT0;
    end
  end

  logic [3:0][3:0] sh_dig;
  logic [3:0]      sh_blk;
  logic [3:0]      dig_a_q, dig_b_q, dig_c_q, dig_d_q, blank_q;
  logic            frame_vld_q, seg_err_q, sel_err_q, ord_err_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= WAIT0;
      exp_q       <= 2'd0;
      stab_q      <= '0;
      dwell_done_q <= 1'b0;
      idle_q      <= '0;
      frame_go_q  <= 1'b0;
      frame_vld_q <= 1'b0;
      sh_dig      <= '0;
      sh_blk      <= '0;
      dig_a_q     <= '0;
      dig_b_q     <= '0;
      dig_c_q     <= '0;
      dig_d_q     <= '0;
      blank_q     <= '0;
      seg_err_q   <= 1'b0;
      sel_err_q   <= 1'b0;
      ord_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      stab_q       <= sel_bad ? '0 : stab_now;
      dwell_done_q <= commit || (dwell_done_q && !sl_chg);
      idle_q       <= idle_d;
      if (sh_we) begin
        sh_dig[sel_idx] <= dec[3:0];
        sh_blk[sel_idx] <= dec[4];
      end
      // The last shadow lands on the commit edge; publish one cycle later.
      frame_go_q  <= frame_go_d;
      frame_vld_q <= frame_go_q;
      if (frame_go_q) begin
        dig_a_q <= sh_dig[0];
        dig_b_q <= sh_dig[1];
        dig_c_q <= sh_dig[2];
        dig_d_q <= sh_dig[3];
        blank_q <= sh_blk;
      end
      seg_err_q <= (commit && dec[5]) ? 1'b1 : (bus.Clr ? 1'b0 : seg_err_q);
      sel_err_q <= sel_bad ? 1'b1 : (bus.Clr ? 1'b0 : sel_err_q);
      ord_err_q <= ord_set ? 1'b1 : (bus.Clr ? 1'b0 : ord_err_q);
    end
  end

  assign bus.Dig_a     = dig_a_q;
  assign bus.Dig_b     = dig_b_q;
  assign bus.Dig_c     = dig_c_q;
  assign bus.Dig_d     = dig_d_q;
  assign bus.Blank     = blank_q;
  assign bus.Frame_vld = frame_vld_q;
  assign bus.Seg_err   = seg_err_q;
  assign bus.Sel_err   = sel_err_q;
  assign bus.Ord_err   = ord_err_q;
  assign bus.Stall     = (idle_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_digi_disp_capture.sv
// Directed bench for digi_disp_capture: u0 runs STABLE_CYC=1 / TIMEOUT_CYC=64,
// u1 runs STABLE_CYC=3 / TIMEOUT_CYC=1024; both share the same stimulus.
`timescale 1ns/1ps
module tb_digi_disp_capture;
  logic       Clk;
  logic       Reset;
  logic [7:0] seg;
  logic [3:0] sl;
  logic       clr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int vld0     = 0;
  int vld1     = 0;
  int prev0    = 0;
  int gap0     = 0;

  digi_disp_capture_if if0 ();
  digi_disp_capture_if if1 ();

  assign if0.Seg_in = seg;
  assign if0.Sl_in  = sl;
  assign if0.Clr    = clr;
  assign if1.Seg_in = seg;
  assign if1.Sl_in  = sl;
  assign if1.Clr    = clr;

  digi_disp_capture #(.STABLE_CYC(1), .TIMEOUT_CYC(64)) u0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if0)
  );

  digi_disp_capture #(.STABLE_CYC(3), .TIMEOUT_CYC(1024)) u1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    #1;
    if (if0.Frame_vld) begin
      if (vld0 > 0) gap0 = cyc - prev0;
      prev0 = cyc;
      vld0  = vld0 + 1;
    end
    if (if1.Frame_vld) vld1 = vld1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [3:0] s, input logic [7:0] g);
    sl  = s;
    seg = g;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'hF, 8'h00);
  endtask

  task automatic scan_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    tick(4'b1110, a);
    tick(4'b1101, b);
    tick(4'b1011, c);
    tick(4'b0111, d);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dig_a"}, if0.Dig_a, 0);
    chk({tag, "_dig_b"}, if0.Dig_b, 0);
    chk({tag, "_dig_c"}, if0.Dig_c, 0);
    chk({tag, "_dig_d"}, if0.Dig_d, 0);
    chk({tag, "_blank"}, if0.Blank, 0);
    chk({tag, "_vld"},   if0.Frame_vld, 0);
    chk({tag, "_seg"},   if0.Seg_err, 0);
    chk({tag, "_sel"},   if0.Sel_err, 0);
    chk({tag, "_ord"},   if0.Ord_err, 0);
    chk({tag, "_stall"}, if0.Stall, 0);
  endtask

  initial begin
    int b0;
    int b1;
    Reset = 1'b1;
    sl    = 4'hF;
    seg   = 8'h00;
    clr   = 1'b0;
    repeat (3) @(negedge Clk);
    chk_zero("rst");
    chk("rst_u1_dig_a", if1.Dig_a, 0);
    Reset = 1'b0;
    idle(2);

    // Continuous one-cycle-per-digit scan
    b0 = vld0;
    repeat (3) scan_frame(8'h3F, 8'h06, 8'h5B, 8'h4F);
    idle(4);
    chk("scan_frames", vld0 - b0, 3);
    chk("scan_gap", gap0, 4);
    chk("scan_dig_a", if0.Dig_a, 4'h0);
    chk("scan_dig_b", if0.Dig_b, 4'h1);
    chk("scan_dig_c", if0.Dig_c, 4'h2);
    chk("scan_dig_d", if0.Dig_d, 4'h3);
    chk("scan_blank", if0.Blank, 4'h0);
    chk("scan_errs", {if0.Seg_err, if0.Sel_err, if0.Ord_err, if0.Stall}, 4'h0);

    // Blank digit, alternate 6 pattern, exact frame latency
    scan_frame(8'h3F, 8'h00, 8'h7C, 8'h4F);
    idle(2);
    chk("lat_early", if0.Frame_vld, 0);
    idle(1);
    chk("lat_pulse", if0.Frame_vld, 1);
    idle(1);
    chk("lat_after", if0.Frame_vld, 0);
    chk("blk_dig_b", if0.Dig_b, 4'hF);
    chk("blk_blank", if0.Blank, 4'b0010);
    chk("blk_dig_c", if0.Dig_c, 4'h6);
    chk("blk_seg_err", if0.Seg_err, 0);

    // Unrecognised pattern still completes the frame
    b0 = vld0;
    scan_frame(8'h3F, 8'h49, 8'h5B, 8'h4F);
    idle(4);
    chk("bad_frames", vld0 - b0, 1);
    chk("bad_seg_err", if0.Seg_err, 1);
    chk("bad_dig_b", if0.Dig_b, 4'hF);
    chk("bad_blank", if0.Blank, 4'h0);
    clr = 1'b1;
    tick(4'hF, 8'h00);
    clr = 1'b0;
    chk("bad_clr", if0.Seg_err, 0);

    // Order error: a,c,a,b,c,d
    b0 = vld0;
    tick(4'b1110, 8'h3F);
    tick(4'b1011, 8'h4F);
    scan_frame(8'h66, 8'h6D, 8'h7D, 8'h07);
    idle(4);
    chk("ord_err", if0.Ord_err, 1);
    chk("ord_frames", vld0 - b0, 1);
    chk("ord_dig_a", if0.Dig_a, 4'h4);
    chk("ord_dig_b", if0.Dig_b, 4'h5);
    chk("ord_dig_c", if0.Dig_c, 4'h6);
    chk("ord_dig_d", if0.Dig_d, 4'h7);
    clr = 1'b1;
    tick(4'hF, 8'h00);
    clr = 1'b0;
    chk("ord_clr", if0.Ord_err, 0);

    // Illegal select, then Clr, then Clr coincident with the event
    b0 = vld0;
    repeat (3) tick(4'b1100, 8'h3F);
    idle(3);
    chk("sel_err", if0.Sel_err, 1);
    chk("sel_no_commit", vld0 - b0, 0);
    clr = 1'b1;
    tick(4'hF, 8'h00);
    clr = 1'b0;
    chk("sel_clr", if0.Sel_err, 0);
    repeat (4) tick(4'b1100, 8'h3F);
    clr = 1'b1;
    tick(4'b1100, 8'h3F);
    clr = 1'b0;
    chk("sel_set_wins", if0.Sel_err, 1);
    idle(3);
    clr = 1'b1;
    tick(4'hF, 8'h00);
    clr = 1'b0;
    chk("sel_clr2", if0.Sel_err, 0);

    // Timeout mid-frame, discard of the partial frame, recovery
    b0 = vld0;
    tick(4'b1110, 8'h3F);
    tick(4'b1101, 8'h06);
    idle(50);
    chk("tmo_before", if0.Stall, 0);
    idle(20);
    chk("tmo_stall", if0.Stall, 1);
    tick(4'b1011, 8'h7F);
    chk("tmo_hold", if0.Stall, 1);
    tick(4'b0111, 8'h67);
    tick(4'hF, 8'h00);
    chk("tmo_cleared", if0.Stall, 0);
    idle(4);
    chk("tmo_discard", vld0 - b0, 0);
    chk("tmo_no_ord", if0.Ord_err, 0);
    chk("tmo_dig_hold", if0.Dig_a, 4'h4);
    scan_frame(8'h07, 8'h7F, 8'h6F, 8'h3F);
    idle(4);
    chk("tmo_new_frame", vld0 - b0, 1);
    chk("tmo_dig_a", if0.Dig_a, 4'h7);
    chk("tmo_dig_b", if0.Dig_b, 4'h8);
    chk("tmo_dig_c", if0.Dig_c, 4'h9);
    chk("tmo_dig_d", if0.Dig_d, 4'h0);

    // Reset mid-frame
    b0 = vld0;
    tick(4'b1110, 8'h5B);
    tick(4'b1101, 8'h4F);
    Reset = 1'b1;
    idle(2);
    chk_zero("mid_rst");
    Reset = 1'b0;
    tick(4'b1011, 8'h66);
    tick(4'b0111, 8'h6D);
    idle(4);
    chk("mid_rst_frames", vld0 - b0, 0);
    chk("mid_rst_dig_d", if0.Dig_d, 0);

    // STABLE_CYC=3: glitch before commit, changes after commit ignored
    Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
    idle(2);
    b1 = vld1;
    tick(4'b1110, 8'h3F);
    repeat (4) tick(4'b1110, 8'h06);
    repeat (2) tick(4'b1110, 8'h5B);
    repeat (3) tick(4'b1101, 8'h06);
    repeat (3) tick(4'b1011, 8'h5B);
    repeat (3) tick(4'b0111, 8'h4F);
    idle(2);
    chk("st3_early", if1.Frame_vld, 0);
    idle(1);
    chk("st3_pulse", if1.Frame_vld, 1);
    idle(1);
    chk("st3_after", if1.Frame_vld, 0);
    chk("st3_frames", vld1 - b1, 1);
    chk("st3_dig_a", if1.Dig_a, 4'h1);
    chk("st3_dig_b", if1.Dig_b, 4'h1);
    chk("st3_dig_c", if1.Dig_c, 4'h2);
    chk("st3_dig_d", if1.Dig_d, 4'h3);
    chk("st3_errs", {if1.Seg_err, if1.Sel_err, if1.Ord_err}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
